fetch_queue_unit: RTL and testbench

//  Parametrised instruction-fetch front end for the next-generation core. Owns the PC and drives a

---
 rtl/fetch_queue_unit.sv | 125 ++++++++++++
 tb/tb_fetch_queue_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the PC, drives a 1-cycle synchronous imem, queues returned words.
// Latency: first imem_rd in the first cycle after reset release, out_valid two cycles later; 1 instr/cycle sustained.
// Backpressure: out_ready=0 stalls the head; issue stops once queued + in-flight entries reach QDEPTH.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   imem_rd, imem_addr         read strobe and word address to instruction memory
//   imem_data                  read data, valid the cycle after imem_rd
//   redirect_en, redirect_pc   load new PC, flush queue and in-flight fetch
//   out_valid, out_ready       head-of-queue handshake
//   out_inst, out_pc, out_pcplus, opcode, fn, imm, rs2, rs1, rd   head entry and its pre-split fields
//   q_count                    entries currently held in the queue
module fetch_queue_unit #(
   parameter int          DBITS               = 32,
   parameter int          INST_BIT_WIDTH      = 32,
   parameter logic [31:0] START_PC            = 32'h40,
   parameter logic [31:0] INST_SIZE           = 32'd4,
   parameter int          IMEM_ADDR_BIT_WIDTH = 11,
   parameter int          QDEPTH              = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   output logic                           imem_rd,
   output logic [IMEM_ADDR_BIT_WIDTH-1:0] imem_addr,
   input  logic [INST_BIT_WIDTH-1:0]      imem_data,
   input  logic                           redirect_en,
   input  logic [DBITS-1:0]               redirect_pc,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [INST_BIT_WIDTH-1:0]      out_inst,
   output logic [DBITS-1:0]               out_pc,
   output logic [DBITS-1:0]               out_pcplus,
   output logic [3:0]                     opcode,
   output logic [3:0]                     fn,
   output logic [15:0]                    imm,
   output logic [3:0]                     rs2,
   output logic [3:0]                     rs1,
   output logic [3:0]                     rd,
   output logic [$clog2(QDEPTH):0]        q_count
);

   localparam int               PW     = $clog2(QDEPTH);
   localparam logic [DBITS-1:0] PC_INC = DBITS'(INST_SIZE);
   localparam logic [DBITS-1:0] PC_RST = DBITS'(START_PC);
   localparam logic [PW+1:0]    QD     = (PW+2)'(QDEPTH);
   localparam logic [PW-1:0]    PTR_ONE = PW'(1);

   logic [DBITS-1:0]          fetch_pc;
   logic [DBITS-1:0]          inflight_pc;
   logic                      inflight_v;
   logic [INST_BIT_WIDTH-1:0] q_inst [QDEPTH];
   logic [DBITS-1:0]          q_pc   [QDEPTH];
   logic [PW-1:0]             head;
   logic [PW-1:0]             tail;
   logic [PW:0]               count;
   logic [PW+1:0]             occupancy;
   logic                      issue;
   logic                      push;
   logic                      pop;

   // An in-flight fetch already owns a slot, so issuing only while
   // queued + in-flight < QDEPTH guarantees every return finds room.
   assign occupancy = {1'b0, count} + {{(PW+1){1'b0}}, inflight_v};
   assign issue     = !reset && !redirect_en && (occupancy < QD);
   assign imem_rd   = issue;
   assign imem_addr = fetch_pc[IMEM_ADDR_BIT_WIDTH+1:2];

   // A return arriving in a redirect cycle belongs to the old stream.
   assign push      = inflight_v && !redirect_en;
   assign out_valid = (count != '0);
   assign pop       = out_valid && out_ready;
   assign q_count   = count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc    <= PC_RST;
         inflight_pc <= '0;
         inflight_v  <= 1'b0;
         head        <= '0;
         tail        <= '0;
         count       <= '0;
      end else if (redirect_en) begin
         // Flush wins over any handshake this cycle; the popped head is
         // simply discarded along with the rest of the queue.
         fetch_pc   <= {redirect_pc[DBITS-1:2], 2'b00};
         inflight_v <= 1'b0;
         head       <= '0;
         tail       <= '0;
         count      <= '0;
      end else begin
         inflight_v <= issue;
         if (issue) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + PC_INC;
         end
         if (push) begin
            tail <= tail + PTR_ONE;
         end
         if (pop) begin
            head <= head + PTR_ONE;
         end
         count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      end
   end

   // Payload storage needs no reset: slots are only read while count != 0.
   always_ff @(posedge clk) begin
      if (push) begin
         q_inst[tail] <= imem_data;
         q_pc[tail]   <= inflight_pc;
      end
   end

   assign out_inst   = q_inst[head];
   assign out_pc     = q_pc[head];
   assign out_pcplus = out_pc + PC_INC;
   assign opcode     = out_inst[3:0];
   assign fn         = out_inst[7:4];
   assign imm        = out_inst[23:8];
   // rs2 shares bits with the upper nibble of imm by ISA encoding.
   assign rs2        = out_inst[23:20];
   assign rs1        = out_inst[27:24];
   assign rd         = out_inst[31:28];

endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_rd;
   logic [10:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect_en;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic [31:0] out_pcplus;
   logic [3:0]  opcode;
   logic [3:0]  fn;
   logic [15:0] imm;
   logic [3:0]  rs2;
   logic [3:0]  rs1;
   logic [3:0]  rd;
   logic [2:0]  q_count;

   fetch_queue_unit dut (
      .clk(clk), .reset(reset),
      .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_data(imem_data),
      .redirect_en(redirect_en), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_inst(out_inst), .out_pc(out_pc), .out_pcplus(out_pcplus),
      .opcode(opcode), .fn(fn), .imm(imm), .rs2(rs2), .rs1(rs1), .rd(rd),
      .q_count(q_count)
   );

   always #5 clk = ~clk;

   // Memory image: word = its own word address, except one marker word at 0x60.
   function automatic logic [31:0] memfn(input logic [10:0] a);
      return (a == 11'h018) ? 32'h12345678 : {21'b0, a};
   endfunction

   always @(posedge clk) begin
      if (imem_rd) imem_data <= memfn(imem_addr);
   end

   int          n_checks = 0;
   int          n_fails  = 0;
   int          n_pops   = 0;
   logic [31:0] sb[$];
   logic [31:0] mpc = 32'h40;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called just after a falling edge with inputs already driven; samples the
   // cycle, updates the scoreboard, then advances to the next falling edge.
   task automatic tick();
      logic [31:0] e;
      logic [31:0] w;
      logic        exp_rd;
      #1;
      if (reset) begin
         sb.delete();
         mpc = 32'h40;
         chk("rd_in_reset", imem_rd, 0);
         chk("valid_in_reset", out_valid, 0);
      end else begin
         exp_rd = !redirect_en && (sb.size() < 4);
         chk("imem_rd", imem_rd, exp_rd);
         if (out_valid && out_ready) begin
            chk("sb_has_entry", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               w = memfn(e[12:2]);
               n_pops++;
               chk("out_pc", out_pc, e);
               chk("out_inst", out_inst, w);
               chk("out_pcplus", out_pcplus, e + 32'd4);
               chk("opcode", opcode, w[3:0]);
               chk("fn", fn, w[7:4]);
               chk("imm", imm, w[23:8]);
               chk("rs2", rs2, w[23:20]);
               chk("rs1", rs1, w[27:24]);
               chk("rd", rd, w[31:28]);
               if (e == 32'h60) begin
                  chk("t5_opcode", opcode, 4'h8);
                  chk("t5_fn", fn, 4'h7);
                  chk("t5_imm", imm, 16'h3456);
                  chk("t5_rs2", rs2, 4'h3);
                  chk("t5_rs1", rs1, 4'h2);
                  chk("t5_rd", rd, 4'h1);
                  chk("t5_pcplus", out_pcplus, 32'h64);
               end
            end
         end
         if (redirect_en) begin
            sb.delete();
            mpc = {redirect_pc[31:2], 2'b00};
         end else if (imem_rd) begin
            chk("imem_addr", imem_addr, mpc[12:2]);
            sb.push_back(mpc);
            mpc = mpc + 32'd4;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int p0;
      reset       = 1'b1;
      out_ready   = 1'b0;
      redirect_en = 1'b0;
      redirect_pc = '0;
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_rd", imem_rd, 0);
      chk("rst_count", q_count, 0);
      tick();
      reset = 1'b0;

      // Streaming from reset; passes the marker word at 0x60.
      out_ready = 1'b1;
      #1;
      chk("t1_first_rd", imem_rd, 1);
      chk("t1_first_addr", imem_addr, 11'h010);
      chk("t1_valid_c0", out_valid, 0);
      tick();
      chk("t1_valid_c1", out_valid, 0);
      tick();
      chk("t1_valid_c2", out_valid, 1);
      chk("t1_pc_c2", out_pc, 32'h40);
      for (int i = 0; i < 14; i++) begin
         tick();
         chk("t1_sustain", out_valid, 1);
      end

      // Backpressure: fill, then drain in order.
      out_ready = 1'b0;
      do_reset();
      ticks(6);
      #1;
      chk("t2_full_count", q_count, 4);
      chk("t2_full_rd", imem_rd, 0);
      chk("t2_head_pc", out_pc, 32'h40);
      tick();
      p0 = n_pops;
      out_ready = 1'b1;
      ticks(5);
      chk("t2_pops", n_pops - p0, 5);

      // Redirect with three queued entries and one fetch in flight.
      out_ready = 1'b0;
      do_reset();
      ticks(4);
      chk("t3_pre_count", q_count, 3);
      redirect_en = 1'b1;
      redirect_pc = 32'h200;
      tick();
      redirect_en = 1'b0;
      #1;
      chk("t3_count", q_count, 0);
      chk("t3_valid", out_valid, 0);
      chk("t3_addr", imem_addr, 11'h080);
      out_ready = 1'b1;
      tick();
      tick();
      chk("t3_valid2", out_valid, 1);
      chk("t3_pc", out_pc, 32'h200);
      ticks(4);

      // Misaligned redirect target, then back-to-back redirects.
      redirect_en = 1'b1;
      redirect_pc = 32'h203;
      tick();
      redirect_en = 1'b0;
      #1;
      chk("t4_addr", imem_addr, 11'h080);
      tick();
      tick();
      chk("t4_pc", out_pc, 32'h200);
      ticks(3);
      redirect_en = 1'b1;
      redirect_pc = 32'h100;
      tick();
      redirect_pc = 32'h300;
      tick();
      redirect_en = 1'b0;
      #1;
      chk("t4b_addr", imem_addr, 11'h0C0);
      chk("t4b_count", q_count, 0);
      tick();
      tick();
      chk("t4b_valid", out_valid, 1);
      chk("t4b_pc", out_pc, 32'h300);
      ticks(4);

      // Asynchronous reset between clock edges.
      #2;
      reset = 1'b1;
      #1;
      chk("t6_valid", out_valid, 0);
      chk("t6_count", q_count, 0);
      chk("t6_rd", imem_rd, 0);
      sb.delete();
      mpc = 32'h40;
      @(negedge clk);
      tick();
      reset = 1'b0;
      #1;
      chk("t6_rd_after", imem_rd, 1);
      chk("t6_addr_after", imem_addr, 11'h010);
      tick();
      tick();
      chk("t6_valid_after", out_valid, 1);
      chk("t6_pc_after", out_pc, 32'h40);
      ticks(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
